// File: rtl/hex8_capture.sv
// hex8_capture
//   Watches the scanned seg/sel lines of an 8-digit multiplexed seven-segment
//   driver, decodes each lit glyph back to a hex nibble and reassembles the
//   32-bit word being shown. A digit is only taken once its seg/sel pattern has
//   been steady for SETTLE synchronized samples, so scan transitions and short
//   glitches are rejected.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          capture enable; low clears any partial frame
//   seg[6:0]    segment lines, seg[0]=a .. seg[6]=g
//   sel[7:0]    digit selects, sel[k] carries nibble k (bits [4k+3:4k])
//   disp_data   last complete captured word
//   data_valid  one-cycle pulse when disp_data updates
//   glyph_err   qualifies data_valid: some digit of that frame was undecodable
//   sel_err     one-cycle pulse on a stable multi-hot sel sample
//   timeout     one-cycle pulse when a partial frame is dropped for inactivity

module hex8_capture #(
  parameter int unsigned SETTLE         = 4,
  parameter int unsigned TIMEOUT        = 65535,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [6:0]  seg,
  input  logic [7:0]  sel,
  output logic [31:0] disp_data,
  output logic        data_valid,
  output logic        glyph_err,
  output logic        sel_err,
  output logic        timeout
);

  localparam int unsigned CNT_W  = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // Raw line levels that mean "nothing lit / nothing selected". Synchronizers
  // reset to these so that reset looks like blanking rather than a fake
  // all-segments, all-digits sample.
  localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [7:0] SEL_IDLE = SEL_ACTIVE_LOW ? 8'hFF : 8'h00;

  // Returns {undecodable, nibble}; undecodable patterns store nibble 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    logic [4:0] r;
    case (g)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  logic [6:0]        seg_s1_q, seg_s2_q;
  logic [7:0]        sel_s1_q, sel_s2_q;
  logic [14:0]       samp_q, samp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        mask_q, mask_d;
  logic [31:0]       shadow_q, shadow_d;
  logic              ferr_q, ferr_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [31:0]       disp_q, disp_d;
  logic              gerr_q, gerr_d;
  logic              dv_q, dv_d;
  logic              se_q, se_d;
  logic              to_q, to_d;

  logic [6:0] seg_st;
  logic [7:0] sel_st;
  logic       stable_evt;
  logic       multi_hot;
  logic       one_hot;
  logic       accept;
  logic       multi_evt;
  logic [4:0] dec;
  logic [2:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= SEG_IDLE;
      seg_s2_q <= SEG_IDLE;
      sel_s1_q <= SEL_IDLE;
      sel_s2_q <= SEL_IDLE;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      sel_s1_q <= sel;
      sel_s2_q <= sel_s1_q;
    end
  end

  // samp_q holds the normalized sample; cnt_q counts how many further cycles
  // it has been repeated, so cnt_q == SETTLE-1 means SETTLE identical samples.
  always_comb begin
    samp_d = {seg_s2_q ^ SEG_IDLE, sel_s2_q ^ SEL_IDLE};
    if (samp_d != samp_q)
      cnt_d = '0;
    else if (cnt_q == CNT_W'(SETTLE))
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;
  end

  assign seg_st     = samp_q[14:8];
  assign sel_st     = samp_q[7:0];
  assign stable_evt = (cnt_q == CNT_W'(SETTLE - 1));
  assign multi_hot  = |(sel_st & (sel_st - 8'd1));
  assign one_hot    = (sel_st != 8'h00) && !multi_hot;
  assign accept     = en && stable_evt && one_hot;
  assign multi_evt  = en && stable_evt && multi_hot;
  assign dec        = decode_glyph(seg_st);

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_st[i]) idx = 3'(i);
    end
  end

  always_comb begin
    mask_d   = mask_q;
    shadow_d = shadow_q;
    ferr_d   = ferr_q;
    idle_d   = idle_q;
    disp_d   = disp_q;
    gerr_d   = gerr_q;
    dv_d     = 1'b0;
    se_d     = 1'b0;
    to_d     = 1'b0;
    if (!en) begin
      mask_d = 8'h00;
      ferr_d = 1'b0;
      idle_d = '0;
    end else if (multi_evt) begin
      se_d   = 1'b1;
      mask_d = 8'h00;
      ferr_d = 1'b0;
    end else if (accept) begin
      shadow_d[{idx, 2'b00} +: 4] = dec[3:0];
      mask_d = mask_q | sel_st;
      ferr_d = ferr_q | dec[4];
      idle_d = '0;
      // Publishing at this edge makes data_valid appear one cycle after the
      // completing accept, with the mask already free for the next frame.
      if (mask_d == 8'hFF) begin
        disp_d = shadow_d;
        gerr_d = ferr_d;
        dv_d   = 1'b1;
        mask_d = 8'h00;
        ferr_d = 1'b0;
      end
    end else if (mask_q != 8'h00) begin
      if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
        to_d   = 1'b1;
        mask_d = 8'h00;
        ferr_d = 1'b0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q   <= '0;
      cnt_q    <= '0;
      mask_q   <= 8'h00;
      shadow_q <= 32'h0;
      ferr_q   <= 1'b0;
      idle_q   <= '0;
      disp_q   <= 32'h0;
      gerr_q   <= 1'b0;
      dv_q     <= 1'b0;
      se_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      ferr_q   <= ferr_d;
      idle_q   <= idle_d;
      disp_q   <= disp_d;
      gerr_q   <= gerr_d;
      dv_q     <= dv_d;
      se_q     <= se_d;
      to_q     <= to_d;
    end
  end

  assign disp_data  = disp_q;
  assign data_valid = dv_q;
  assign glyph_err  = gerr_q;
  assign sel_err    = se_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_hex8_capture.sv
// Bench for hex8_capture. Two instances see the same scan: one common-anode
// (active-low seg), one with active-high seg fed the inverted pattern. Both
// must report the same words, which the stimulus side predicts into queues.

module tb_hex8_capture;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [6:0]  seg_drv = 7'h7F;
  logic [7:0]  sel_drv = 8'hFF;
  logic [6:0]  seg_b;
  logic [31:0] a_dd, b_dd;
  logic        a_dv, a_ge, a_se, a_to;
  logic        b_dv, b_ge, b_se, b_to;

  assign seg_b = ~seg_drv;

  always #5 clk = ~clk;

  hex8_capture #(.SETTLE(4), .TIMEOUT(100), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .seg(seg_drv), .sel(sel_drv),
    .disp_data(a_dd), .data_valid(a_dv), .glyph_err(a_ge), .sel_err(a_se), .timeout(a_to)
  );

  hex8_capture #(.SETTLE(4), .TIMEOUT(100), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .seg(seg_b), .sel(sel_drv),
    .disp_data(b_dd), .data_valid(b_dv), .glyph_err(b_ge), .sel_err(b_se), .timeout(b_to)
  );

  int          checks = 0;
  int          failures = 0;
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [31:0] last_dd [2];
  int          se_cnt [2];
  int          to_cnt [2];
  int          exp_se = 0;
  int          exp_to = 0;

  task automatic mon(input int id, input logic dv, input logic [31:0] dd,
                     input logic ge, input logic se, input logic to);
    logic [32:0] e;
    int sz;
    sz = (id == 0) ? qa.size() : qb.size();
    if (dv) begin
      checks++;
      if (sz == 0) begin
        failures++;
        $display("FAIL unexpected_valid dut%0d got data=%h expected no valid", id, dd);
      end else begin
        if (id == 0) e = qa.pop_front();
        else         e = qb.pop_front();
        if ({ge, dd} !== e) begin
          failures++;
          $display("FAIL frame dut%0d got gerr=%0b data=%h exp gerr=%0b data=%h",
                   id, ge, dd, e[32], e[31:0]);
        end
      end
    end else if (dd !== last_dd[id]) begin
      checks++;
      failures++;
      $display("FAIL data_without_valid dut%0d got=%h was=%h", id, dd, last_dd[id]);
    end
    last_dd[id] = dd;
    if (se) se_cnt[id]++;
    if (to) to_cnt[id]++;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_dd[0] = 32'h0;
      last_dd[1] = 32'h0;
    end else begin
      mon(0, a_dv, a_dd, a_ge, a_se, a_to);
      mon(1, b_dv, b_dd, b_ge, b_se, b_to);
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    sel_drv = 8'hFF;
    seg_drv = 7'h7F;
    if (n > 0) wait_cyc(n);
  endtask

  // Drives digits lo..hi the way the scanning driver would. fixed>0 gives every
  // digit that dwell with no gaps; glitch_k injects a 2-cycle foreign digit.
  task automatic scan_digits(input logic [31:0] w, input logic [7:0] bad, input int lo,
                             input int hi, input int glitch_k, input int fixed);
    logic [6:0] s;
    for (int k = lo; k <= hi; k++) begin
      s = bad[k] ? ~7'h00 : ~GLYPH[w[4*k +: 4]];
      sel_drv = ~(8'b1 << k);
      seg_drv = s;
      if (k == glitch_k) begin
        wait_cyc(10);
        sel_drv = ~(8'b1 << ((k + 1) % 8));
        seg_drv = ~GLYPH[4'hE];
        wait_cyc(2);
        sel_drv = ~(8'b1 << k);
        seg_drv = s;
        wait_cyc(10);
      end else begin
        wait_cyc(fixed > 0 ? fixed : int'($urandom_range(8, 24)));
      end
      if (fixed == 0) blank(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic scan_frame(input logic [31:0] w, input logic [7:0] bad, input int glitch_k);
    logic [31:0] e;
    e = w;
    for (int k = 0; k < 8; k++) if (bad[k]) e[4*k +: 4] = 4'h0;
    qa.push_back({|bad, e});
    qb.push_back({|bad, e});
    scan_digits(w, bad, 0, 7, glitch_k, 0);
  endtask

  task automatic checkpoint(input string nm);
    blank(14);
    for (int id = 0; id < 2; id++) begin
      check({nm, "_pending"}, 64'((id == 0) ? qa.size() : qb.size()), 64'd0);
      check({nm, "_sel_err"}, 64'(se_cnt[id]), 64'(exp_se));
      check({nm, "_timeout"}, 64'(to_cnt[id]), 64'(exp_to));
    end
  endtask

  initial begin
    int first;
    logic [31:0] w;
    logic [7:0]  bad;
    se_cnt[0] = 0; se_cnt[1] = 0;
    to_cnt[0] = 0; to_cnt[1] = 0;
    last_dd[0] = 32'h0; last_dd[1] = 32'h0;

    wait_cyc(3);
    check("reset_outputs_a", {27'h0, a_dd, a_dv, a_ge, a_se, a_to}, 64'h0);
    check("reset_outputs_b", {27'h0, b_dd, b_dv, b_ge, b_se, b_to}, 64'h0);
    rst_n = 1'b1;
    en = 1'b1;
    blank(10);

    scan_frame(32'h12345678, 8'h00, -1);
    scan_frame(32'h12345678, 8'h00, -1);
    checkpoint("basic");

    scan_frame(32'hFEDCBA98, 8'h00, -1);
    scan_frame(32'h00000000, 8'h00, -1);
    checkpoint("glyphs");

    scan_frame(32'hAAAAAAAA, 8'h08, -1);
    scan_frame(32'hAAAAAAAA, 8'h00, -1);
    checkpoint("bad_glyph");

    scan_frame(32'h13579BDF, 8'h00, 5);
    checkpoint("glitch");

    scan_digits(32'h11111111, 8'h00, 0, 3, -1, 0);
    sel_drv = ~8'h03;
    seg_drv = ~GLYPH[1];
    wait_cyc(10);
    exp_se++;
    blank(5);
    scan_frame($urandom, 8'h00, -1);
    checkpoint("multi_hot");

    scan_digits(32'h89ABCDEF, 8'h00, 0, 4, -1, 20);
    blank(0);
    first = -1;
    for (int i = 1; i <= 150; i++) begin
      wait_cyc(1);
      if (a_to && first < 0) first = i;
    end
    exp_to++;
    checks++;
    if (first < 80 || first > 100) begin
      failures++;
      $display("FAIL timeout_latency got=%0d cycles into blank, exp between 80 and 100", first);
    end
    scan_frame(32'h2468ACE0, 8'h00, -1);
    checkpoint("timeout");

    scan_digits(32'h55555555, 8'h00, 0, 4, -1, 0);
    rst_n = 1'b0;
    wait_cyc(2);
    check("midreset_a", {27'h0, a_dd, a_dv, a_ge, a_se, a_to}, 64'h0);
    check("midreset_b", {27'h0, b_dd, b_dv, b_ge, b_se, b_to}, 64'h0);
    rst_n = 1'b1;
    blank(5);
    scan_frame(32'hCAFEBABE, 8'h00, -1);
    checkpoint("reset");

    w = $urandom;
    scan_digits(w, 8'h00, 0, 3, -1, 0);
    blank(3);
    en = 1'b0;
    scan_digits(w, 8'h00, 4, 7, -1, 0);
    blank(3);
    en = 1'b1;
    blank(3);
    scan_frame(32'hDEADBEEF, 8'h00, -1);
    checkpoint("enable");

    repeat (6) begin
      bad = ($urandom_range(0, 3) == 0) ? (8'b1 << $urandom_range(0, 7)) : 8'h00;
      scan_frame($urandom, bad, -1);
    end
    checkpoint("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex8_capture.md
Name: hex8_capture

Overview:
- Receive-side counterpart of the 8-digit multiplexed seven-segment driver.
- Watches the scanned seg/sel lines and decodes each lit glyph back to a hex nibble.
- Reassembles the 32-bit word the driver is showing and reports it with a one-cycle valid pulse.
- Used for loopback self-check of the display path and as a bench monitor.

Parameters:
- SETTLE, 4: consecutive identical synchronized seg/sel samples required before a digit is accepted.
- TIMEOUT, 65535: idle cycles with no accepted digit before a partial frame is discarded.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when its seg bit is 0 (common anode).
- SEL_ACTIVE_LOW, 1: 1 = digit selected when its sel bit is 0.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  capture enable
- seg  input  7  segment lines, seg[0]=a … seg[6]=g
- sel  input  8  digit selects; sel[k] carries nibble k = bits [4k+3:4k]
- disp_data  output  32  last complete captured word
- data_valid  output  1  one-cycle pulse when disp_data updates
- glyph_err  output  1  valid with data_valid; 1 if any digit in that frame was undecodable
- sel_err  output  1  one-cycle pulse on a multi-hot sel sample
- timeout  output  1  one-cycle pulse when a partial frame is dropped

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: disp_data=0, data_valid=0, glyph_err=0, sel_err=0, timeout=0. Internal state cleared: synchronizers, stable counter, digit mask, frame error, idle counter.
- Input conditioning: seg and sel each pass through a 2-FF synchronizer. Polarity is normalized to active-high after sync, per the two polarity parameters.
- Stability counter:
  - Resets to 0 when the current normalized {seg,sel} differs from the previous cycle's value.
  - Otherwise increments, saturating at SETTLE.
  - A digit is accepted on the single cycle the count reaches SETTLE−1 with sel one-hot, so each dwell yields exactly one accept.
- Sel classification:
  - All-zero: blanking, ignored.
  - Multi-hot: sel_err pulses once per stable dwell, and the partial frame is discarded (mask and frame error cleared).
- Glyph decode, normalized gfedcba, hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Any other pattern stores nibble 0 and sets the frame error flag.
- Accept of digit k: write the nibble into a shadow register at [4k+3:4k] and set mask[k]. Re-accepting k before the frame completes overwrites the nibble; the mask is unchanged.
- Frame completion: when the mask becomes 8'hFF (from an accept), on the next clock:
  - disp_data ← shadow, glyph_err ← frame error, data_valid=1 for 1 cycle.
  - Mask and frame error clear.
  - Latency from the completing accept to data_valid: 1 cycle.
  - An accept in the completion cycle begins the next frame.
- Timeout:
  - The idle counter clears on every accept and counts otherwise.
  - On reaching TIMEOUT with mask≠0: clear mask and frame error, pulse timeout.
  - With mask=0 the counter holds and no pulse is issued.
- en=0: no accepts; mask, frame error and idle counter are cleared. Outputs hold their last values; pulses are 0. Synchronizers keep running.
- Reset mid-frame discards everything. No data_valid is issued until 8 fresh digits are accepted.
- disp_data changes only together with data_valid.

Test Plan:
- Active-low polarity: drive the driver's scan pattern for 0x12345678, 20 cycles per digit, en=1 → data_valid after the 8th digit, disp_data=32'h12345678, glyph_err=0. Repeats once per full scan.
- Glyph table: scan 0xFEDCBA98, then 0x00000000 → both words captured exactly. Repeat with SEG_ACTIVE_LOW=0 and inverted stimulus → same results.
- Bad glyph: digit 3 shows normalized 7'h00 (blank) in a frame of 0xAAAAAAAA → disp_data=32'hAAAA0AAA, glyph_err=1 with data_valid. The next clean frame gives glyph_err=0.
- Glitch rejection: a 2-cycle sel/seg glitch (shorter than SETTLE) mid-dwell → no extra accept, word unchanged. Multi-hot sel=8'b0000_0011 held 10 cycles → one sel_err pulse, partial frame dropped, next full scan valid.
- Timeout: TIMEOUT=100; scan digits 0–4, then hold sel all-off 150 cycles → one timeout pulse at idle count 100, no data_valid. The next full scan is valid.
- Reset/enable: assert rst_n low after 5 digits → all outputs 0. Release, scan 0xCAFEBABE → valid. Deassert en after 4 digits → no valid. Re-enable and scan a full frame → single valid, correct word.
